// File: rtl/sbox_pkg.sv
// Shared types and constants for the S_BOX request scheduler.
package sbox_pkg;

    localparam int BYTE_W   = 8;
    localparam int NB_WORD  = 4;
    localparam int NB_STATE = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    typedef enum logic {
        REQ_WORD  = 1'b0,
        REQ_STATE = 1'b1
    } req_id_e;

    // Byte i of a 16-byte operand (byte 0 = bits [7:0]).
    function automatic logic [BYTE_W-1:0] get_byte(input logic [NB_STATE*BYTE_W-1:0] v,
                                                   input logic [3:0] i);
        return v[i*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the
// requester that did not win last time. last_grant moves on every grant.
module rr_arb2 #(
    parameter logic RST_LAST = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic       gnt_vld_o,
    output logic       gnt_id_o
);

    logic last_q;

    // Winner selection; only meaningful when gnt_vld_o is high.
    always_comb begin
        gnt_vld_o = en_i & (|req_i);
        if (&req_i) gnt_id_o = ~last_q;
        else        gnt_id_o = req_i[1];
    end

    // Remember who won so the next tie goes the other way.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          last_q <= RST_LAST;
        else if (gnt_vld_o) last_q <= gnt_id_o;
    end

endmodule

// File: rtl/sbox_sched.sv
// Shares one pipelined byte S_BOX between a 4-byte SubWord requester and a
// 16-byte SubBytes requester: issue one byte per cycle, capture the results
// SBOX_LAT cycles later, then pulse the winner's done for one cycle.
module sbox_sched
    import sbox_pkg::*;
#(
    parameter int SBOX_LAT = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         word_req,
    input  logic [31:0]  word_in,
    output logic [31:0]  word_out,
    output logic         word_done,
    input  logic         state_req,
    input  logic [127:0] state_in,
    output logic [127:0] state_out,
    output logic         state_done,
    output logic         busy,
    output logic [7:0]   sbox_sel,
    output logic         sbox_en,
    input  logic [7:0]   sbox_data
);

    fsm_e           state_q, state_d;
    req_id_e        gnt_q, gnt_d;
    logic [127:0]   op_q, op_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [7:0]     sel_q, sel_d;
    logic           en_q, en_d;
    logic [31:0]    wout_q, wout_d;
    logic [127:0]   sout_q, sout_d;

    // Capture pipeline: valid + byte index, aligned with the S_BOX latency.
    logic [SBOX_LAT-1:0]       vld_pipe;
    logic [SBOX_LAT-1:0][3:0]  idx_pipe;

    logic           gnt_vld, gnt_id;
    logic [3:0]     last_idx;
    logic           cap_vld;
    logic [3:0]     cap_idx;

    rr_arb2 #(.RST_LAST(REQ_STATE)) u_arb (
        .clk_i    (CLK),
        .rst_i    (RST),
        .en_i     (state_q == ST_IDLE),
        .req_i    ({state_req, word_req}),
        .gnt_vld_o(gnt_vld),
        .gnt_id_o (gnt_id)
    );

    assign last_idx = (gnt_q == REQ_WORD) ? 4'(NB_WORD - 1) : 4'(NB_STATE - 1);
    assign cap_vld  = vld_pipe[SBOX_LAT-1];
    assign cap_idx  = idx_pipe[SBOX_LAT-1];

    // FSM next state, issue sequencing and result capture.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        en_d    = en_q;
        wout_d  = wout_q;
        sout_d  = sout_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    gnt_d   = req_id_e'(gnt_id);
                    op_d    = gnt_id ? state_in : {96'b0, word_in};
                    sel_d   = gnt_id ? state_in[7:0] : word_in[7:0];
                    en_d    = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (en_q) begin
                    if (cnt_q == last_idx) begin
                        en_d  = 1'b0;
                        sel_d = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        sel_d = get_byte(op_q, cnt_q + 4'd1);
                    end
                end
                if (cap_vld) begin
                    if (gnt_q == REQ_WORD) wout_d[cap_idx[1:0]*BYTE_W +: BYTE_W] = sbox_data;
                    else                   sout_d[cap_idx*BYTE_W +: BYTE_W]      = sbox_data;
                    if (cap_idx == last_idx) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= REQ_WORD;
            op_q    <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            wout_q  <= '0;
            sout_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            wout_q  <= wout_d;
            sout_q  <= sout_d;
        end
    end

    // Track each issued byte until its S_BOX result appears on sbox_data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
        end else begin
            vld_pipe[0] <= en_q;
            idx_pipe[0] <= cnt_q;
            for (int i = 1; i < SBOX_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    assign word_out   = wout_q;
    assign state_out  = sout_q;
    assign word_done  = (state_q == ST_DONE) && (gnt_q == REQ_WORD);
    assign state_done = (state_q == ST_DONE) && (gnt_q == REQ_STATE);
    assign busy       = (state_q != ST_IDLE);
    assign sbox_sel   = sel_q;
    assign sbox_en    = en_q;

endmodule
